// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: shared state, instruction and opcode definitions for the program sequencer
package program_sequencer_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;
   localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;
   typedef struct packed {
      logic [7:0] op;
      logic [7:0] arg;
   } instr_t;
endpackage

// File: rtl/program_memory.sv
// program_memory: program store with synchronous write and asynchronous read
module program_memory #(
   parameter int AW = 5,
   parameter int W = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [2**AW];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: loads (opcode, operand) pairs and issues them one per clock to the execution unit
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int ROM_ADDRESS_WIDTH = 5,
   parameter int INPUT_DATA_WIDTH = 4,
   parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          load_start,
   input  logic                          load_done,
   input  logic [7:0]                    byte_in,
   input  logic                          byte_valid,
   output logic                          byte_ready,
   input  logic                          run_start,
   input  logic                          halt,
   input  logic                          step,
   input  logic                          loop_en,
   output logic [2*INPUT_DATA_WIDTH-1:0] pc_o,
   output logic [2*INPUT_DATA_WIDTH-1:0] opcode_o,
   output logic [2*INPUT_DATA_WIDTH-1:0] operand_o,
   output logic                          valid_o,
   output logic [ROM_ADDRESS_WIDTH:0]    prog_len,
   output logic                          busy
);
   localparam int DW = 2 * INPUT_DATA_WIDTH;
   localparam logic [ROM_ADDRESS_WIDTH:0] FULL = {1'b1, {ROM_ADDRESS_WIDTH{1'b0}}};
   state_t state, state_d;
   logic [ROM_ADDRESS_WIDTH-1:0] pc, pc_d;
   logic [ROM_ADDRESS_WIDTH:0] prog_len_d;
   logic phase, phase_d, we, issue, last, accept;
   logic [7:0] op_q, op_d;
   logic [DW-1:0] pc_o_d, opcode_o_d, operand_o_d;
   logic valid_d, byte_ready_d, busy_d;
   logic [15:0] rdata;
   instr_t ins;

   program_memory #(.AW(ROM_ADDRESS_WIDTH), .W(16)) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (prog_len[ROM_ADDRESS_WIDTH-1:0]),
      .wdata ({op_q, byte_in}),
      .raddr (pc),
      .rdata (rdata)
   );

   assign ins = rdata;
   assign accept = byte_valid && byte_ready;
   assign last = ({1'b0, pc} == prog_len - 1'b1);

   always_comb begin
      state_d = state;
      pc_d = pc;
      prog_len_d = prog_len;
      phase_d = phase;
      op_d = op_q;
      pc_o_d = pc_o;
      opcode_o_d = opcode_o;
      operand_o_d = operand_o;
      valid_d = 1'b0;
      we = 1'b0;
      issue = 1'b0;
      if (load_start) begin
         state_d = LOAD;
         prog_len_d = '0;
         phase_d = 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) begin
                  phase_d = ~phase;
                  op_d = phase ? op_q : byte_in;
                  we = phase;
                  prog_len_d = phase ? prog_len + 1'b1 : prog_len;
               end
               if (load_done) begin
                  state_d = IDLE;
                  phase_d = 1'b0;
               end
            end
            IDLE, DONE: if (run_start) begin
               pc_d = '0;
               state_d = (prog_len == '0) ? DONE : RUN;
            end
            RUN: if (halt) state_d = PAUSE; else issue = 1'b1;
            PAUSE: if (!halt) begin
               issue = step;
               if (!step && run_start) state_d = RUN;
            end
            default: state_d = IDLE;
         endcase
         // a step issue shares the RUN rules; only DONE transitions override PAUSE
         if (issue) begin
            if (ins.op == HALT_OPCODE) state_d = DONE;
            else begin
               pc_o_d = DW'(pc);
               opcode_o_d = DW'(ins.op);
               operand_o_d = DW'(ins.arg);
               valid_d = 1'b1;
               pc_d = last ? (loop_en ? '0 : pc) : pc + 1'b1;
               if (last && !loop_en) state_d = DONE;
            end
         end
      end
      byte_ready_d = (state_d == LOAD) && (prog_len_d < FULL);
      busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == PAUSE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc <= '0;
         prog_len <= '0;
         phase <= 1'b0;
         op_q <= '0;
         pc_o <= '0;
         opcode_o <= '0;
         operand_o <= '0;
         valid_o <= 1'b0;
         byte_ready <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_d;
         pc <= pc_d;
         prog_len <= prog_len_d;
         phase <= phase_d;
         op_q <= op_d;
         pc_o <= pc_o_d;
         opcode_o <= opcode_o_d;
         operand_o <= operand_o_d;
         valid_o <= valid_d;
         byte_ready <= byte_ready_d;
         busy <= busy_d;
      end
   end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: scoreboard bench comparing issued instructions against a program-level model
module tb_program_sequencer;
   logic clk = 1'b0, reset = 1'b1;
   logic load_start = 0, load_done = 0, byte_valid = 0, run_start = 0, halt = 0, step = 0, loop_en = 0;
   logic [7:0] byte_in = '0;
   logic byte_ready, valid_o, busy;
   logic [7:0] pc_o, opcode_o, operand_o;
   logic [5:0] prog_len;

   program_sequencer dut (
      .clk(clk), .reset(reset), .load_start(load_start), .load_done(load_done),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .run_start(run_start), .halt(halt), .step(step), .loop_en(loop_en),
      .pc_o(pc_o), .opcode_o(opcode_o), .operand_o(operand_o), .valid_o(valid_o),
      .prog_len(prog_len), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pc;
      logic [7:0] op;
      logic [7:0] arg;
      int at;
   } exp_t;

   exp_t exp_q[$];
   logic [7:0] bq[$];
   logic [15:0] model_mem [32];
   int model_len = 0;
   int vectors = 0, miscompares = 0, cyc = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, got, got, want, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (valid_o) begin
         if (exp_q.size() == 0) chk("unexpected_issue_pc", pc_o, -1);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("issue_pc", pc_o, e.pc);
            chk("issue_op", opcode_o, e.op);
            chk("issue_arg", operand_o, e.arg);
            if (e.at >= 0) chk("issue_cycle", cyc, e.at);
         end
      end
   end

   task automatic push_one(input int pc, input int at);
      exp_t e;
      e.pc = pc;
      e.op = model_mem[pc][15:8];
      e.arg = model_mem[pc][7:0];
      e.at = at;
      exp_q.push_back(e);
   endtask

   // walk the program from pc 0 until its end or the first HALT opcode
   task automatic push_run(input int first_at);
      for (int i = 0; i < model_len; i++) begin
         if (model_mem[i][15:8] == 8'hFF) break;
         push_one(i, first_at + i);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         tick();
         t++;
      end
      chk({name, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (3) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ld);
      int t = 0;
      while (!byte_ready && t < 20) begin
         tick();
         t++;
      end
      if (t == 20) chk("byte_ready_timeout", byte_ready, 1);
      byte_in = b;
      byte_valid = 1;
      load_done = ld;
      tick();
      byte_valid = 0;
      load_done = 0;
   endtask

   task automatic load_seq(input bit merge);
      load_start = 1;
      tick();
      load_start = 0;
      chk("load_busy", busy, 1);
      for (int i = 0; i < bq.size(); i++) send_byte(bq[i], merge && i == bq.size() - 1);
      if (!merge) begin
         load_done = 1;
         tick();
         load_done = 0;
      end
      model_len = bq.size() / 2;
      for (int i = 0; i < model_len; i++) model_mem[i] = {bq[2*i], bq[2*i+1]};
      chk("prog_len", prog_len, model_len);
      chk("idle_after_load_busy", busy, 0);
   endtask

   task automatic run_and_check(input string name);
      push_run(cyc + 2);
      run_start = 1;
      tick();
      run_start = 0;
      chk({name, "_busy_start"}, busy, model_len > 0);
      wait_drain(name);
      chk({name, "_busy_end"}, busy, 0);
      chk({name, "_valid_end"}, valid_o, 0);
   endtask

   task automatic rand_bytes(input int pairs);
      bq.delete();
      for (int i = 0; i < pairs; i++) begin
         bq.push_back(($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
         bq.push_back(8'($urandom));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (2) tick();
      reset = 0;
      chk("rst_valid", valid_o, 0);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prog_len", prog_len, 0);
      chk("rst_pc_o", pc_o, 0);
      chk("rst_opcode_o", opcode_o, 0);
      chk("rst_operand_o", operand_o, 0);

      bq = {8'h10, 8'hA1, 8'h20, 8'hB2, 8'h30, 8'hC3};
      load_seq(0);
      run_and_check("basic3");
      chk("basic3_prog_len", prog_len, 3);

      bq = {8'h10, 8'h01, 8'hFF, 8'h00, 8'h20, 8'h02};
      load_seq(0);
      run_and_check("halt_op");

      bq = {8'h41, 8'h11, 8'h42, 8'h22};
      load_seq(0);
      loop_en = 1;
      k = cyc;
      for (int i = 0; i < 8; i++) push_one(i % 2, k + 2 + i);
      run_start = 1;
      tick();
      run_start = 0;
      repeat (6) tick();
      loop_en = 0;
      wait_drain("loop");
      chk("loop_busy_end", busy, 0);

      bq = {8'h01, 8'hE0, 8'h02, 8'hE1, 8'h03, 8'hE2, 8'h04, 8'hE3};
      load_seq(0);
      k = cyc;
      push_one(0, k + 2);
      push_one(1, k + 3);
      run_start = 1;
      tick();
      run_start = 0;
      repeat (2) tick();
      halt = 1;
      tick();
      halt = 0;
      chk("halt_valid", valid_o, 0);
      chk("halt_busy", busy, 1);
      repeat (2) tick();
      chk("halt_pending", exp_q.size(), 0);
      push_one(2, cyc + 1);
      step = 1;
      tick();
      step = 0;
      repeat (3) tick();
      chk("step_pending", exp_q.size(), 0);
      chk("step_busy", busy, 1);
      push_one(3, cyc + 2);
      run_start = 1;
      tick();
      run_start = 0;
      wait_drain("resume");
      chk("resume_busy_end", busy, 0);

      load_start = 1;
      tick();
      load_start = 0;
      bq.delete();
      byte_valid = 1;
      for (int i = 0; i < 70; i++) begin
         byte_in = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 254));
         bq.push_back(byte_in);
         tick();
      end
      byte_valid = 0;
      chk("full_byte_ready", byte_ready, 0);
      chk("full_prog_len", prog_len, 32);
      load_done = 1;
      tick();
      load_done = 0;
      model_len = 32;
      for (int i = 0; i < 32; i++) model_mem[i] = {bq[2*i], bq[2*i+1]};
      chk("full_prog_len_done", prog_len, 32);
      run_and_check("full");

      bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      load_seq(0);
      run_and_check("odd");

      bq = {8'h66, 8'h77, 8'h88, 8'h99};
      load_seq(1);
      run_and_check("merge");

      bq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
      load_seq(0);
      k = cyc;
      for (int i = 0; i < 3; i++) push_one(i, k + 2 + i);
      run_start = 1;
      tick();
      run_start = 0;
      repeat (3) tick();
      reset = 1;
      tick();
      reset = 0;
      model_len = 0;
      chk("midrst_valid", valid_o, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_prog_len", prog_len, 0);
      chk("midrst_byte_ready", byte_ready, 0);
      chk("midrst_pending", exp_q.size(), 0);
      run_and_check("empty_run");

      for (int it = 0; it < 10; it++) begin
         bit odd, merge;
         rand_bytes($urandom_range(1, 12));
         odd = $urandom_range(0, 2) == 0;
         merge = !odd && $urandom_range(0, 1) == 1;
         if (odd) bq.push_back(8'($urandom));
         load_seq(merge);
         run_and_check("random");
         chk("random_prog_len_kept", prog_len, model_len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Program store and sequencer that feeds the SPI CPU execution unit. Accepts a byte stream of (opcode, operand) pairs in LOAD mode and stores them in a small program memory. In RUN mode it issues one instruction per clock on the exec unit's pc/opcode/operand/valid inputs, with halt, single-step, resume and loop control. It sits between the SPI byte receiver and the execution unit.

Parameters:
ROM_ADDRESS_WIDTH, 5, program memory address width; depth = 2**ROM_ADDRESS_WIDTH instructions.
INPUT_DATA_WIDTH, 4, nibble width; opcode, operand and pc are INPUT_DATA_WIDTH*2 bits wide.
HALT_OPCODE, 8'hFF, opcode that terminates execution; it is never issued.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  pulse: enter LOAD, clear program
load_done  in  1  pulse: leave LOAD
byte_in  in  8  program byte from SPI receiver
byte_valid  in  1  byte_in valid
byte_ready  out  1  sequencer can accept byte
run_start  in  1  pulse: start from 0 (IDLE/DONE) or resume (PAUSE)
halt  in  1  pulse: pause execution
step  in  1  pulse: issue one instruction while paused
loop_en  in  1  level: wrap pc to 0 after last instruction
pc_o  out  8  pc of the issued instruction
opcode_o  out  8  issued opcode
operand_o  out  8  issued operand
valid_o  out  1  opcode_o/operand_o valid this cycle
prog_len  out  ROM_ADDRESS_WIDTH+1  number of instructions loaded
busy  out  1  high in LOAD, RUN and PAUSE

Behaviour:
- Only one clock and one reset are used. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state IDLE; pc, prog_len, write address and byte phase are 0. pc_o, opcode_o, operand_o, valid_o and byte_ready are 0. Memory contents are not cleared.
- States: IDLE, LOAD, RUN, PAUSE, DONE. All outputs are registered.
- Command priority in the same cycle: reset > load_start > halt > step > run_start.
- load_start (any state): go to LOAD. Write address, prog_len and byte phase = 0. valid_o = 0. In LOAD, other commands are ignored except load_done.
- LOAD transfer: a byte is accepted when byte_valid and byte_ready are both high.
  - Phase 0: latch the byte as the opcode.
  - Phase 1: write {opcode, byte} to mem[addr]; addr+1; prog_len+1.
  - byte_ready = (state==LOAD) and (prog_len < 2**ROM_ADDRESS_WIDTH). It drops the cycle after the last slot is written.
- load_done in LOAD: go to IDLE. A pending phase-0 byte is discarded. A load_done in the same cycle as a byte transfer takes the byte first.
- run_start in IDLE/DONE: pc = 0. If prog_len == 0, go to DONE with no issue; otherwise go to RUN.
- RUN, each cycle, with ins = mem[pc]:
  - If ins.op == HALT_OPCODE: valid_o = 0, go to DONE, pc unchanged.
  - Otherwise: pc_o = pc, opcode_o = ins.op, operand_o = ins.arg, valid_o = 1.
    - If pc == prog_len-1: with loop_en, pc = 0 and stay in RUN; without loop_en, go to DONE.
    - Else pc = pc+1.
- Latency: run_start at edge N gives first valid_o at edge N+2 (transition edge, then issue edge). Thereafter one instruction per cycle, no bubbles, including across a loop wrap.
- halt in RUN: go to PAUSE. No issue on that edge; valid_o = 0; pc holds the next un-issued address.
- step in PAUSE: perform exactly one RUN-cycle issue (including the HALT/end/wrap rules), then stay in PAUSE unless the rules move it to DONE.
- run_start in PAUSE: go to RUN and continue from the held pc.
- valid_o is a one-cycle-per-instruction strobe. It is 0 in IDLE, LOAD, PAUSE (except on step issue edges) and DONE. opcode_o, operand_o and pc_o hold their last values when valid_o = 0.
- Commands not listed for a state are ignored.

Decomposition:
- Package program_sequencer_pkg: state enum (IDLE, LOAD, RUN, PAUSE, DONE), HALT_OPCODE default, instruction struct {op[7:0], arg[7:0]}.
- Sub-module program_memory: 2**ROM_ADDRESS_WIDTH x 16, synchronous write, asynchronous read. The sequencer registers the read data onto its outputs.

Test Plan:
- Load 3 pairs (10,A1),(20,B2),(30,C3); run_start -> valid_o for 3 consecutive cycles with pc_o 0,1,2 and the matching bytes; then DONE, busy=0, prog_len=3.
- Load (10,01),(FF,00),(20,02); run -> only pc 0 issued; DONE one cycle later; the HALT opcode never appears with valid_o=1.
- Load 2 instructions, loop_en=1, run 6 cycles -> pc_o 0,1,0,1,0,1 with no gap; deassert loop_en -> DONE after the next pc 1.
- Load 4 instructions, run, halt after pc 1 issues -> valid_o=0. step -> pc 2 issued once. run_start -> pc 3, then DONE.
- Stream 70 bytes with byte_valid held high -> 64 bytes accepted, byte_ready low afterwards, prog_len=32. Send an odd byte then load_done -> prog_len unchanged.
- reset asserted mid-RUN -> next edge valid_o=0, state IDLE, prog_len=0. run_start -> DONE, no issue.
